// File: rtl/audio_i2s_tx.sv
// Stereo PCM serializer: push FIFO in, XCK/BCK/LRCK/DATA out in I2S or left-justified framing.
// Optional build macro AUDIO_I2S_TX_ATTEN_EN adds iATTEN for per-frame arithmetic attenuation.
module audio_i2s_tx #(
   parameter int SAMPLE_W   = 16,
   parameter int SLOT_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int BCK_DIV    = 6
) (
   input  logic                            iCLK,
   input  logic                            iRST_N,
   input  logic [2*SAMPLE_W-1:0]           iDATA,
   input  logic                            iDATA_WR,
   output logic                            oFULL,
   output logic [$clog2(FIFO_DEPTH):0]     oLEVEL,
   input  logic                            iMODE,
   output logic                            oUNDERRUN,
   input  logic                            iCLR_UNDERRUN,
`ifdef AUDIO_I2S_TX_ATTEN_EN
   input  logic [3:0]                      iATTEN,
`endif
   output logic                            oAUD_XCK,
   output logic                            oAUD_BCK,
   output logic                            oAUD_LRCK,
   output logic                            oAUD_DATA
);

   localparam int FRAME_W = 2 * SLOT_W;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int DIV_W   = $clog2(BCK_DIV + 1);
   localparam int BIT_W   = $clog2(FRAME_W);

   logic [DIV_W-1:0]      div_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [BIT_W-1:0]      bit_nxt;
   logic [FRAME_W-1:0]    shift_q;
   logic [FRAME_W-1:0]    shift_d;
   logic [FRAME_W-1:0]    frame_word;
   logic [2*SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [2*SAMPLE_W-1:0] head;
   logic [SAMPLE_W-1:0]   left_s;
   logic [SAMPLE_W-1:0]   right_s;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           level_q;
   logic [AW:0]           level_d;
   logic                  xck_q;
   logic                  bck_q;
   logic                  lrck_q;
   logic                  data_q;
   logic                  mode_q;
   logic                  mode_d;
   logic                  underrun_q;
   logic                  full_q;
   logic                  bck_tc;
   logic                  fall_ev;
   logic                  frame_start;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;

   // Timing strobes: every data/LRCK change happens on the edge that drops BCK.
   always_comb begin
      bck_tc      = (div_cnt == DIV_W'(BCK_DIV - 1));
      fall_ev     = bck_tc && bck_q;
      bit_nxt     = (bit_cnt == BIT_W'(FRAME_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
      frame_start = fall_ev && (bit_cnt == BIT_W'(FRAME_W - 1));
      fifo_empty  = (level_q == '0);
      pop         = frame_start && !fifo_empty;
      push        = iDATA_WR && (!full_q || pop);
   end

   // Frame assembly from the FIFO head; an empty FIFO yields a silent frame.
   always_comb begin
      head       = fifo_mem[rd_ptr];
`ifdef AUDIO_I2S_TX_ATTEN_EN
      left_s     = SAMPLE_W'($signed(head[2*SAMPLE_W-1 -: SAMPLE_W]) >>> iATTEN);
      right_s    = SAMPLE_W'($signed(head[SAMPLE_W-1:0]) >>> iATTEN);
`else
      left_s     = head[2*SAMPLE_W-1 -: SAMPLE_W];
      right_s    = head[SAMPLE_W-1:0];
`endif
      frame_word = '0;
      if (pop) begin
         frame_word[FRAME_W-1 -: SAMPLE_W] = left_s;
         frame_word[SLOT_W-1 -: SAMPLE_W]  = right_s;
      end
      shift_d = shift_q;
      if (frame_start) begin
         shift_d = frame_word;
      end else if (fall_ev) begin
         shift_d = {shift_q[FRAME_W-2:0], 1'b0};
      end
      mode_d  = frame_start ? iMODE : mode_q;
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + (AW+1)'(1);
      end else if (!push && pop) begin
         level_d = level_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge iCLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= iDATA;
      end
   end

   // Clock generation, bit counter, serializer and FIFO bookkeeping.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         xck_q      <= 1'b0;
         bck_q      <= 1'b0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         lrck_q     <= 1'b0;
         shift_q    <= '0;
         data_q     <= 1'b0;
         mode_q     <= 1'b0;
         underrun_q <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
      end else begin
         xck_q <= ~xck_q;
         if (bck_tc) begin
            div_cnt <= '0;
            bck_q   <= ~bck_q;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
         shift_q <= shift_d;
         mode_q  <= mode_d;
         if (fall_ev) begin
            bit_cnt <= bit_nxt;
            lrck_q  <= (bit_nxt >= BIT_W'(SLOT_W));
            // I2S takes the pre-shift MSB, which delays the stream by one BCK.
            data_q  <= mode_d ? shift_d[FRAME_W-1] : shift_q[FRAME_W-1];
         end
         if (frame_start && fifo_empty) begin
            underrun_q <= 1'b1;
         end else if (iCLR_UNDERRUN) begin
            underrun_q <= 1'b0;
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level_q <= level_d;
         full_q  <= (level_d == (AW+1)'(FIFO_DEPTH));
      end
   end

   assign oAUD_XCK  = xck_q;
   assign oAUD_BCK  = bck_q;
   assign oAUD_LRCK = lrck_q;
   assign oAUD_DATA = data_q;
   assign oUNDERRUN = underrun_q;
   assign oLEVEL    = level_q;
   assign oFULL     = full_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: framing vectors from a table plus FIFO fill,
// frame-start push/pop, underrun and reset sequences.
module tb_audio_i2s_tx;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic [31:0] iDATA = '0;
   logic        iDATA_WR = 1'b0;
   logic        oFULL;
   logic [4:0]  oLEVEL;
   logic        iMODE = 1'b0;
   logic        oUNDERRUN;
   logic        iCLR_UNDERRUN = 1'b0;
`ifdef AUDIO_I2S_TX_ATTEN_EN
   logic [3:0]  iATTEN = '0;
`endif
   logic        oAUD_XCK;
   logic        oAUD_BCK;
   logic        oAUD_LRCK;
   logic        oAUD_DATA;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        mode;
      logic [31:0] sample;
      logic [3:0]  atten;
      logic [31:0] expFrame;
      logic [31:0] expNext;
   } vec_t;

   vec_t vecs [7];

   audio_i2s_tx dut (
      .iCLK          (iCLK),
      .iRST_N        (iRST_N),
      .iDATA         (iDATA),
      .iDATA_WR      (iDATA_WR),
      .oFULL         (oFULL),
      .oLEVEL        (oLEVEL),
      .iMODE         (iMODE),
      .oUNDERRUN     (oUNDERRUN),
      .iCLR_UNDERRUN (iCLR_UNDERRUN),
`ifdef AUDIO_I2S_TX_ATTEN_EN
      .iATTEN        (iATTEN),
`endif
      .oAUD_XCK      (oAUD_XCK),
      .oAUD_BCK      (oAUD_BCK),
      .oAUD_LRCK     (oAUD_LRCK),
      .oAUD_DATA     (oAUD_DATA)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic nextRise();
      logic last;
      logic ok;
      last = oAUD_BCK;
      ok   = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge iCLK);
         if (oAUD_BCK && !last) ok = 1'b1;
         last = oAUD_BCK;
      end
      if (!ok) timeoutFail("bck_rise");
   endtask

   task automatic readFrame(output logic [31:0] bits, output logic [31:0] lr);
      logic prevLr;
      logic found;
      prevLr = 1'b1;
      found  = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         nextRise();
         if (!oAUD_LRCK && prevLr) found = 1'b1;
         else prevLr = oAUD_LRCK;
      end
      if (!found) timeoutFail("frame_start");
      bits[31] = oAUD_DATA;
      lr[31]   = oAUD_LRCK;
      for (int b = 30; b >= 0; b--) begin
         nextRise();
         bits[b] = oAUD_DATA;
         lr[b]   = oAUD_LRCK;
      end
   endtask

   task automatic alignRight();
      for (int i = 0; i < 40; i++) begin
         nextRise();
         if (oAUD_LRCK) break;
      end
   endtask

   task automatic alignLeft();
      for (int i = 0; i < 40; i++) begin
         nextRise();
         if (!oAUD_LRCK) break;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] sample);
      iDATA    = sample;
      iDATA_WR = 1'b1;
      @(negedge iCLK);
      iDATA_WR = 1'b0;
   endtask

   initial begin
      logic [31:0] bits;
      logic [31:0] lr;
      logic [15:0] hi;
      logic [15:0] lo;
      logic        prev;
      logic        seen;
      int          n;

      vecs[0] = '{1'b1, 32'hA5C30F01, 4'd0, 32'hA5C30F01, 32'h00000000};
      vecs[1] = '{1'b0, 32'hA5C30F01, 4'd0, 32'h52E18780, 32'h80000000};
      vecs[2] = '{1'b1, 32'h12348001, 4'd0, 32'h12348001, 32'h00000000};
      vecs[3] = '{1'b0, 32'h12348001, 4'd0, 32'h091A4000, 32'h80000000};
      vecs[4] = '{1'b0, 32'h80000002, 4'd0, 32'h40000001, 32'h00000000};
`ifdef AUDIO_I2S_TX_ATTEN_EN
      vecs[5] = '{1'b1, 32'h80000040, 4'd2, 32'hE0000010, 32'h00000000};
      vecs[6] = '{1'b1, 32'h7FF0FFF0, 4'd4, 32'h07FFFFFF, 32'h00000000};
`else
      vecs[5] = '{1'b1, 32'h80000040, 4'd2, 32'h80000040, 32'h00000000};
      vecs[6] = '{1'b1, 32'h7FF0FFF0, 4'd4, 32'h7FF0FFF0, 32'h00000000};
`endif

      repeat (3) @(negedge iCLK);
      checkOutput("rst_xck", oAUD_XCK, 0);
      checkOutput("rst_bck", oAUD_BCK, 0);
      checkOutput("rst_lrck", oAUD_LRCK, 0);
      checkOutput("rst_data", oAUD_DATA, 0);
      checkOutput("rst_underrun", oUNDERRUN, 0);
      checkOutput("rst_full", oFULL, 0);
      checkOutput("rst_level", oLEVEL, 0);

      iRST_N = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge iCLK);
         checkOutput("xck_toggle", oAUD_XCK, k % 2);
      end

      readFrame(bits, lr);
      checkOutput("idle_data", bits, 32'h0);
      checkOutput("idle_lrck", lr, 32'h0000FFFF);
      checkOutput("underrun_before_first", oUNDERRUN, 0);
      repeat (6) @(negedge iCLK);
      checkOutput("first_frame_lrck", oAUD_LRCK, 0);
      checkOutput("underrun_set", oUNDERRUN, 1);
      iCLR_UNDERRUN = 1'b1;
      @(negedge iCLK);
      iCLR_UNDERRUN = 1'b0;
      checkOutput("underrun_clr", oUNDERRUN, 0);
      repeat (100) @(negedge iCLK);
      checkOutput("underrun_held", oUNDERRUN, 0);
      prev = oAUD_LRCK;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge iCLK);
         if (!oAUD_LRCK && prev) seen = 1'b1;
         prev = oAUD_LRCK;
      end
      if (!seen) timeoutFail("lrck_fall");
      checkOutput("underrun_reset", oUNDERRUN, 1);

      prev = oAUD_LRCK;
      seen = 1'b0;
      for (int i = 0; i < 800 && !seen; i++) begin
         @(negedge iCLK);
         if (oAUD_LRCK && !prev) seen = 1'b1;
         prev = oAUD_LRCK;
      end
      if (!seen) timeoutFail("lrck_rise");
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 800 && !seen; i++) begin
         @(negedge iCLK);
         n++;
         if (oAUD_LRCK && !prev) seen = 1'b1;
         prev = oAUD_LRCK;
      end
      checkOutput("lrck_period", n, 384);

      nextRise();
      n    = 0;
      prev = oAUD_BCK;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge iCLK);
         n++;
         if (oAUD_BCK && !prev) seen = 1'b1;
         prev = oAUD_BCK;
      end
      checkOutput("bck_period", n, 12);

      for (int v = 0; v < 7; v++) begin
         iMODE = vecs[v].mode;
`ifdef AUDIO_I2S_TX_ATTEN_EN
         iATTEN = vecs[v].atten;
`endif
         alignRight();
         applyStimulus(vecs[v].sample);
         readFrame(bits, lr);
         checkOutput($sformatf("vec%0d_frame", v), bits, vecs[v].expFrame);
         checkOutput($sformatf("vec%0d_lrck", v), lr, 32'h0000FFFF);
         readFrame(bits, lr);
         checkOutput($sformatf("vec%0d_next", v), bits, vecs[v].expNext);
      end
`ifdef AUDIO_I2S_TX_ATTEN_EN
      iATTEN = '0;
`endif

      iMODE = 1'b1;
      alignRight();
      iDATA_WR = 1'b1;
      for (int i = 0; i < 17; i++) begin
         hi    = 16'hA000 + 16'(i);
         lo    = 16'h5000 + 16'(i);
         iDATA = {hi, lo};
         @(negedge iCLK);
      end
      iDATA_WR = 1'b0;
      checkOutput("fill_level", oLEVEL, 16);
      checkOutput("fill_full", oFULL, 1);
      for (int i = 0; i < 16; i++) begin
         hi = 16'hA000 + 16'(i);
         lo = 16'h5000 + 16'(i);
         readFrame(bits, lr);
         checkOutput($sformatf("fill_order%0d", i), bits, {hi, lo});
      end
      readFrame(bits, lr);
      checkOutput("fill_dropped", bits, 32'h0);
      checkOutput("drain_level", oLEVEL, 0);
      checkOutput("drain_full", oFULL, 0);

      alignRight();
      alignLeft();
      iDATA_WR = 1'b1;
      for (int i = 0; i < 16; i++) begin
         hi    = 16'hC000 + 16'(i);
         lo    = 16'h3000 + 16'(i);
         iDATA = {hi, lo};
         @(negedge iCLK);
      end
      iDATA_WR = 1'b0;
      checkOutput("sim_prefill", oLEVEL, 16);
      alignRight();
      repeat (15) nextRise();
      repeat (5) @(negedge iCLK);
      iDATA    = {16'hC010, 16'h3010};
      iDATA_WR = 1'b1;
      @(negedge iCLK);
      iDATA_WR = 1'b0;
      checkOutput("sim_pop_edge", oAUD_LRCK, 0);
      checkOutput("sim_level", oLEVEL, 16);
      checkOutput("sim_full", oFULL, 1);
      for (int i = 0; i < 17; i++) begin
         hi = 16'hC000 + 16'(i);
         lo = 16'h3000 + 16'(i);
         readFrame(bits, lr);
         checkOutput($sformatf("sim_order%0d", i), bits, {hi, lo});
      end

      alignRight();
      applyStimulus(32'h11112222);
      repeat (3) @(negedge iCLK);
      #2 iRST_N = 1'b0;
      #1;
      checkOutput("midrst_level", oLEVEL, 0);
      checkOutput("midrst_underrun", oUNDERRUN, 0);
      checkOutput("midrst_xck", oAUD_XCK, 0);
      checkOutput("midrst_bck", oAUD_BCK, 0);
      checkOutput("midrst_lrck", oAUD_LRCK, 0);
      @(negedge iCLK);
      iRST_N = 1'b1;
      readFrame(bits, lr);
      checkOutput("postrst_frame0", bits, 32'h0);
      checkOutput("postrst_lrck", lr, 32'h0000FFFF);
      readFrame(bits, lr);
      checkOutput("postrst_flushed", bits, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
